fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences instruction fetch for the front end. It owns the fetch PC and drives the fetch datapath's request/address inputs, holding each request until the response arrives. Returned instruction words are buffered with their PC in a small in-order instruction queue consumed by decode. It handles control-flow redirects (branch mispredict, jump, trap), including a redirect that arrives while a request is outstanding.

Parameters:
- WIDTH, 32, address and instruction width.
- DEPTH, 8, instruction queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0060, first fetch address after reset.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset: asynchronous, active-low.
- redirect  in  1  pulse; flush and refetch from redirect_pc.
- redirect_pc  in  WIDTH  new fetch target; valid when redirect=1.
- fetch_req  out  1  request to fetch datapath (drives its dequeue/read input).
- fetch_addr  out  WIDTH  address to fetch datapath.
- fetch_rdy  in  1  response valid (memory response), one cycle per request.
- fetch_data  in  WIDTH  instruction word; valid when fetch_rdy=1.
- iq_valid  out  1  queue head valid.
- iq_instr  out  WIDTH  head instruction.
- iq_pc  out  WIDTH  head instruction's PC.
- iq_deq  in  1  decode pops head; ignored when iq_valid=0.
- iq_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (asynchronous on rst_n low): state=IDLE, pc=RESET_PC, queue empty, fetch_req=0, iq_valid=0, iq_count=0. Deasserting rst_n mid-request abandons the request. Memory is reset by the same rst_n.
- fetch_req is 1 iff state is REQ or DROP. fetch_addr=pc in every state. pc changes only at the edge that ends a request, or on redirect.
- At most one request outstanding. While fetch_req=1, fetch_addr is held stable until fetch_rdy.
- States:
  - IDLE: no request. Next state is REQ when the queue has space (count<DEPTH, counting this cycle's pop), else stay IDLE.
  - REQ: wait for fetch_rdy. On fetch_rdy: push {pc, fetch_data}; pc<=pc+4. Next state is REQ (back-to-back, new address the following cycle) if the post-push/pop count<DEPTH, else IDLE.
  - DROP: a redirect hit an outstanding request. Keep fetch_req=1 at the new pc until fetch_rdy. Discard that data, do not advance pc, then go to REQ.
- Redirect (highest priority, any state):
  - Queue is flushed; count=0 next cycle. Same-cycle iq_deq and push are discarded.
  - pc<=redirect_pc.
  - From IDLE: go to REQ.
  - From REQ with fetch_rdy=0: go to DROP.
  - From REQ with fetch_rdy=1 in the same cycle: data discarded, go to REQ.
  - From DROP: stay DROP (a new redirect_pc overrides the old one). If fetch_rdy=1 in the same cycle, go to REQ.
- Latency: fetch_rdy at edge N makes the entry visible (iq_valid) after edge N. The first request is issued the cycle after reset release.
- Queue:
  - Circular buffer, read/write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle is allowed at any occupancy, including full, when pop is legal.
  - A pop when empty is ignored.
  - A push when full cannot occur, because space is reserved before issue; the bench asserts this.
- pc+4 wraps modulo 2^WIDTH. redirect_pc is used unmodified; alignment is the producer's duty.

Decomposition:
- Shared package fetch_pkg: fetch_state_t enum {IDLE, REQ, DROP}; iq_entry_t struct {pc, instr}.
- Sub-module fetch_queue: parameterised FIFO of iq_entry_t with push, pop, flush, count, head. Flush has priority over push and pop.
- fetch_ctrl contains the FSM, pc register and space check.

Test Plan:
- Reset then single-cycle memory (fetch_rdy the cycle after each fetch_req), no iq_deq -> addresses 0x60, 0x64 … 0x7C issued; queue fills to 8; fetch_req drops to 0; iq_pc=0x60, iq_instr=first data.
- Full queue, one iq_deq per cycle, memory 3-cycle latency -> fetch_req reasserts the cycle after the first pop; pcs stay in order; count never exceeds 8.
- Request to 0x64 outstanding, redirect to 0x200 for 2 cycles before fetch_rdy -> fetch_addr=0x200 with fetch_req held; returned word discarded; next response is queued with iq_pc=0x200; queue empty meanwhile.
- redirect (pc 0x300) in the same cycle as fetch_rdy and iq_deq on a 3-entry queue -> count=0 next cycle, data dropped, new request to 0x300 with no DROP state.
- Second redirect (0x400) while in DROP from 0x300 -> after fetch_rdy, the first queued entry has iq_pc=0x400.
- rst_n pulled low mid-REQ, asynchronously between edges -> fetch_req and iq_valid go to 0 immediately; after release, fetching restarts at 0x60.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: FSM state encoding and instruction-queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no request outstanding
        REQ  = 2'd1,   // request outstanding, response will be queued
        DROP = 2'd2    // request outstanding, response belongs to a flushed path
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular instruction queue (push/pop/flush), head exposed combinationally.
// Latency: a push at edge N is visible at the head after edge N.
// Backpressure: none internally; the producer reserves space before issuing, flush wins over push/pop.
// Ports: flush/push/push_dat/pop in; head_vld/head_dat/count out.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = iq_entry_t,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  entry_t      push_dat,
    input  logic        pop,
    output logic        head_vld,
    output entry_t      head_dat,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    entry_t        mem_q [DEPTH];

    logic pop_ok;
    logic push_ok;

    // A pop on an empty queue is ignored; a push at full is only taken
    // together with a legal pop so an entry is never overwritten.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != FULL) || pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_vld = (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one request at a time, queues {pc, instr} for decode.
// Latency: request issued the cycle after reset release; fetch_rdy at edge N is at iq head after edge N.
// Backpressure: no request is issued unless the queue has a free slot (counting this cycle's pop).
// Ports: redirect/redirect_pc in; fetch_req/fetch_addr out, fetch_rdy/fetch_data in;
//        iq_valid/iq_instr/iq_pc/iq_count out, iq_deq in.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter int unsigned       DEPTH    = 8,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(32'h0000_0060)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic                     fetch_req,
    output logic [WIDTH-1:0]         fetch_addr,
    input  logic                     fetch_rdy,
    input  logic [WIDTH-1:0]         fetch_data,
    output logic                     iq_valid,
    output logic [WIDTH-1:0]         iq_instr,
    output logic [WIDTH-1:0]         iq_pc,
    input  logic                     iq_deq,
    output logic [$clog2(DEPTH):0]   iq_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Same layout as iq_entry_t, but sized by this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fetch_req_q, fetch_req_d;

    logic             q_push;
    logic             q_pop;
    entry_t           q_push_dat;
    entry_t           q_head;
    logic [CW-1:0]    q_count;
    logic [CW-1:0]    cnt_after_pop;
    logic             room_now;
    logic             room_after_push;

    assign q_pop         = iq_deq && iq_valid;
    assign cnt_after_pop = q_count - CW'(q_pop);
    assign room_now        = cnt_after_pop < CW'(DEPTH);
    // Next request may only issue if the entry landing now still leaves a slot.
    assign room_after_push = cnt_after_pop < CW'(DEPTH - 1);

    assign q_push     = (state_q == REQ) && fetch_rdy && !redirect;
    assign q_push_dat = '{pc: pc_q, instr: fetch_data};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
            // An outstanding request that has not returned yet must have its
            // response swallowed; otherwise the new target is fetched directly.
            case (state_q)
                REQ, DROP: state_d = fetch_rdy ? REQ : DROP;
                default:   state_d = REQ;
            endcase
        end else begin
            case (state_q)
                IDLE: if (room_now) state_d = REQ;
                REQ: begin
                    if (fetch_rdy) begin
                        pc_d    = pc_q + WIDTH'(4);
                        state_d = room_after_push ? REQ : IDLE;
                    end
                end
                DROP: if (fetch_rdy) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign fetch_req_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            fetch_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_req_q <= fetch_req_d;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (q_pop),
        .head_vld (iq_valid),
        .head_dat (q_head),
        .count    (q_count)
    );

    assign fetch_req  = fetch_req_q;
    assign fetch_addr = pc_q;
    assign iq_instr   = q_head.instr;
    assign iq_pc      = q_head.pc;
    assign iq_count   = q_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_rdy = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        iq_valid;
    logic [31:0] iq_instr;
    logic [31:0] iq_pc;
    logic        iq_deq = 1'b0;
    logic [3:0]  iq_count;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_rdy   (fetch_rdy),
        .fetch_data  (fetch_data),
        .iq_valid    (iq_valid),
        .iq_instr    (iq_instr),
        .iq_pc       (iq_pc),
        .iq_deq      (iq_deq),
        .iq_count    (iq_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Abstract view: expected queue contents, the PC the next fetch targets,
    // whether a request is being driven, and whether its response is stale.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_pc;
    bit          m_req;
    bit          m_stale;

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0000_0060;
        m_req   = 0;
        m_stale = 0;
    endtask

    task automatic model_step();
        if (redirect) begin
            mq.delete();
            m_stale = m_req && !fetch_rdy;
            m_req   = 1;
            m_pc    = redirect_pc;
        end else begin
            if (iq_deq && mq.size() > 0) void'(mq.pop_front());
            if (m_req && fetch_rdy) begin
                if (m_stale) begin
                    m_stale = 0;
                end else begin
                    chk("push_space", 32'(mq.size() < DEPTH), 32'd1);
                    mq.push_back('{pc: m_pc, instr: fetch_data});
                    m_pc  = m_pc + 32'd4;
                    m_req = (mq.size() < DEPTH);
                end
            end else if (!m_req) begin
                m_req = (mq.size() < DEPTH);
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".fetch_req"},  32'(fetch_req), 32'(m_req));
        chk({tag, ".fetch_addr"}, fetch_addr, m_pc);
        chk({tag, ".iq_count"},   32'(iq_count), 32'(mq.size()));
        chk({tag, ".iq_valid"},   32'(iq_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, ".iq_pc"},    iq_pc,    mq[0].pc);
            chk({tag, ".iq_instr"}, iq_instr, mq[0].instr);
        end
    endtask

    // ---------------- memory responder ----------------
    int mem_wait = 0;
    int mem_lat  = 1;
    int lat_min  = 1;
    int lat_max  = 1;

    task automatic tick();
        bit req_pre;
        req_pre = fetch_req;
        @(posedge clk);
        model_step();
        if (fetch_rdy) begin
            mem_wait = 0;
            mem_lat  = $urandom_range(lat_min, lat_max);
        end else if (req_pre) begin
            mem_wait++;
        end
        #1;
    endtask

    task automatic set_in(input bit r, input logic [31:0] rpc, input bit rdy, input logic [31:0] dat, input bit deq);
        redirect    = r;
        redirect_pc = rpc;
        fetch_rdy   = rdy;
        fetch_data  = dat;
        iq_deq      = deq;
    endtask

    // Answers the current request after mem_lat cycles of fetch_req.
    task automatic drive_auto(input int deq_pct, input int redir_pct);
        fetch_rdy  = fetch_req && (mem_wait + 1 >= mem_lat);
        fetch_data = $urandom;
        iq_deq     = ($urandom_range(0, 99) < deq_pct);
        redirect   = ($urandom_range(0, 99) < redir_pct);
        if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF4;
        else                           redirect_pc = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic do_reset();
        set_in(0, '0, 0, '0, 0);
        rst_n = 1'b0;
        model_reset();
        mem_wait = 0;
        mem_lat  = lat_min;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.fetch_req",  32'(fetch_req), 32'd0);
        chk("rst.iq_valid",   32'(iq_valid),  32'd0);
        chk("rst.iq_count",   32'(iq_count),  32'd0);
        chk("rst.fetch_addr", fetch_addr,     32'h60);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // ---------------- table: fill from reset with single-cycle memory ----------------
    typedef struct {
        logic        rdy;
        logic [31:0] dat;
        logic        exp_req;
        logic [31:0] exp_addr;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[10];
    int   max_cnt;

    initial begin
        tbl[0] = '{rdy: 1'b0, dat: 32'h0, exp_req: 1'b1, exp_addr: 32'h60, exp_cnt: 0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{rdy: 1'b1, dat: 32'hC0DE_0000 + 32'(i), exp_req: (i < 8),
                       exp_addr: 32'h60 + 32'(4 * i), exp_cnt: i};
        tbl[9] = '{rdy: 1'b0, dat: 32'h0, exp_req: 1'b0, exp_addr: 32'h80, exp_cnt: 8};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(0, '0, tbl[i].rdy, tbl[i].dat, 0);
            tick();
            chk($sformatf("fill[%0d].fetch_req", i),  32'(fetch_req), 32'(tbl[i].exp_req));
            chk($sformatf("fill[%0d].fetch_addr", i), fetch_addr, tbl[i].exp_addr);
            chk($sformatf("fill[%0d].iq_count", i),   32'(iq_count), 32'(tbl[i].exp_cnt));
            if (tbl[i].exp_cnt > 0) begin
                chk($sformatf("fill[%0d].iq_pc", i),    iq_pc,    32'h60);
                chk($sformatf("fill[%0d].iq_instr", i), iq_instr, 32'hC0DE_0001);
            end
        end

        // Full queue drained one per cycle, 3-cycle memory.
        lat_min = 3; lat_max = 3; mem_lat = 3; mem_wait = 0;
        set_in(0, '0, 0, '0, 1);
        tick();
        chk("drain.first_pop_req", 32'(fetch_req), 32'd1);
        chk("drain.first_pop_cnt", 32'(iq_count), 32'd7);
        max_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            drive_auto(100, 0);
            tick();
            check_model("drain");
            if (int'(iq_count) > max_cnt) max_cnt = int'(iq_count);
        end
        chk("drain.max_count_le_8", 32'(max_cnt <= DEPTH), 32'd1);

        // Redirect held 2 cycles over an outstanding request to 0x64.
        lat_min = 1; lat_max = 1;
        do_reset();
        set_in(0, '0, 0, '0, 0);               tick();
        set_in(0, '0, 1, 32'hAAAA_0060, 0);    tick();
        chk("rd1.addr_before", fetch_addr, 32'h64);
        set_in(1, 32'h200, 0, '0, 0);          tick();
        chk("rd1.drop_req", 32'(fetch_req), 32'd1);
        chk("rd1.drop_addr", fetch_addr, 32'h200);
        chk("rd1.flushed", 32'(iq_count), 32'd0);
        set_in(1, 32'h200, 0, '0, 0);          tick(); check_model("rd1.hold");
        set_in(0, '0, 1, 32'hDEAD_0064, 0);    tick();
        chk("rd1.discard_cnt", 32'(iq_count), 32'd0);
        chk("rd1.discard_addr", fetch_addr, 32'h200);
        set_in(0, '0, 1, 32'hB000_0200, 0);    tick();
        chk("rd1.iq_pc", iq_pc, 32'h200);
        chk("rd1.iq_instr", iq_instr, 32'hB000_0200);
        check_model("rd1.after");

        // Redirect coinciding with fetch_rdy and iq_deq on a 3-entry queue.
        set_in(0, '0, 1, 32'hC000_0204, 0);    tick();
        set_in(0, '0, 1, 32'hC000_0208, 0);    tick();
        chk("rd2.pre_cnt", 32'(iq_count), 32'd3);
        set_in(1, 32'h300, 1, 32'hDEAD_020C, 1); tick();
        chk("rd2.cnt", 32'(iq_count), 32'd0);
        chk("rd2.addr", fetch_addr, 32'h300);
        set_in(0, '0, 1, 32'hF000_0300, 0);    tick();
        chk("rd2.no_drop_cnt", 32'(iq_count), 32'd1);
        chk("rd2.iq_pc", iq_pc, 32'h300);
        check_model("rd2");

        // Second redirect while already dropping, then redirect+rdy out of DROP.
        set_in(1, 32'h300, 0, '0, 0);          tick(); check_model("rd3.a");
        set_in(1, 32'h400, 0, '0, 0);          tick();
        chk("rd3.addr", fetch_addr, 32'h400);
        set_in(0, '0, 1, 32'hDEAD_0300, 0);    tick(); check_model("rd3.b");
        set_in(0, '0, 1, 32'h1111_0400, 0);    tick();
        chk("rd3.iq_pc", iq_pc, 32'h400);
        set_in(1, 32'h500, 0, '0, 0);          tick();
        set_in(1, 32'h600, 1, 32'hDEAD_0500, 0); tick(); check_model("rd4.a");
        set_in(0, '0, 1, 32'h2222_0600, 0);    tick();
        chk("rd4.iq_pc", iq_pc, 32'h600);
        check_model("rd4.b");

        // Asynchronous reset between edges with a request in flight.
        set_in(0, '0, 0, '0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.fetch_req", 32'(fetch_req), 32'd0);
        chk("arst.iq_valid",  32'(iq_valid),  32'd0);
        chk("arst.iq_count",  32'(iq_count),  32'd0);
        chk("arst.addr",      fetch_addr,     32'h60);
        model_reset();
        mem_wait = 0;
        #2 rst_n = 1'b1;
        tick();
        chk("arst.restart_req", 32'(fetch_req), 32'd1);
        chk("arst.restart_addr", fetch_addr, 32'h60);
        set_in(0, '0, 1, 32'h3333_0060, 0);    tick();
        check_model("arst.after");

        // PC increment wraps past the top of the address space.
        set_in(1, 32'hFFFF_FFFC, 0, '0, 0);    tick();
        set_in(0, '0, 1, 32'hDEAD_0064, 0);    tick();
        set_in(0, '0, 1, 32'h4444_FFFC, 0);    tick();
        chk("wrap.addr", fetch_addr, 32'h0);
        chk("wrap.iq_pc", iq_pc, 32'hFFFF_FFFC);
        check_model("wrap");

        // Randomized run against the model.
        lat_min = 1; lat_max = 4;
        do_reset();
        max_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            drive_auto(40, 4);
            tick();
            check_model("rand");
            if (int'(iq_count) > max_cnt) max_cnt = int'(iq_count);
        end
        chk("rand.max_count_le_8", 32'(max_cnt <= DEPTH), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
